// File: rtl/apb_image_slave_if.sv
// APB (AMBA 2) bus bundle between the stimulus initiator and the image slave.
// No PREADY/PSLVERR: every transfer completes in one ACCESS cycle.
interface apb_image_slave_if #(
    parameter int unsigned Amba_Word       = 24,
    parameter int unsigned Amba_Addr_Depth = 13
);
    logic [Amba_Addr_Depth-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [Amba_Word-1:0]       PWDATA;
    logic [Amba_Word-1:0]       PRDATA;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA
    );
endinterface

// File: rtl/apb_image_slave.sv
// APB responder for the cat recognizer: CTRL/STATUS registers, image/weight
// word memory, start/busy handshake with the core and a registered core read port.
module apb_image_slave #(
    parameter int unsigned Amba_Word        = 24,
    parameter int unsigned Amba_Addr_Depth  = 13,
    parameter int unsigned Weight_precision = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    apb_image_slave_if.slave           apb,
    output logic                       start,
    output logic                       busy,
    input  logic [Amba_Addr_Depth-1:0] core_rd_addr,
    output logic [Amba_Word-1:0]       core_rd_data,
    input  logic                       done,
    input  logic                       cat_result
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [Amba_Addr_Depth-1:0] MEM_BASE = Amba_Addr_Depth'(2);

    state_t                     state_q, state_d;
    logic [Amba_Addr_Depth-1:0] addr_q, addr_d;
    logic                       write_q, write_d;
    logic [Amba_Word-1:0]       prdata_q, prdata_d;
    logic [Amba_Word-1:0]       core_rd_data_q, core_rd_data_d;
    logic                       start_q, start_d;
    logic                       busy_q, busy_d;
    logic                       rv_q, rv_d;
    logic                       result_q, result_d;

    logic                       access_fire;
    logic                       mem_we;
    logic                       ctrl_start;
    logic                       done_eff;
    logic [Amba_Word-1:0]       status_word;
    logic [Amba_Word-1:0]       rd_mux;

    logic [Amba_Word-1:0]       mem [0:(1 << Amba_Addr_Depth)-1];

    always_comb begin
        status_word      = '0;
        status_word[2:0] = {result_q, rv_q, busy_q};
        if (apb.PADDR >= MEM_BASE) begin
            rd_mux = mem[apb.PADDR];
        end else if (apb.PADDR == '0) begin
            rd_mux = '0;
        end else begin
            rd_mux = status_word;
        end
    end

    // state_q trails the bus phase by one cycle: SETUP means the setup phase
    // was seen, so the APB access phase occurs while state_q == SETUP.
    always_comb begin
        state_d     = IDLE;
        access_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (apb.PSEL && !apb.PENABLE) state_d = SETUP;
            end
            SETUP: begin
                if (apb.PSEL && apb.PENABLE) begin
                    state_d     = ACCESS;
                    access_fire = 1'b1;
                end else if (apb.PSEL) begin
                    state_d = SETUP;
                end
            end
            ACCESS: begin
                if (apb.PSEL && !apb.PENABLE) state_d = SETUP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        write_d    = write_q;
        prdata_d   = prdata_q;
        mem_we     = 1'b0;
        ctrl_start = 1'b0;
        busy_d     = busy_q;
        rv_d       = rv_q;
        result_d   = result_q;
        done_eff   = done && busy_q;

        if (state_d == SETUP) begin
            addr_d  = apb.PADDR;
            write_d = apb.PWRITE;
            if (!apb.PWRITE) prdata_d = rd_mux;
        end

        // A done in the same cycle frees the core before the start request is judged.
        if (access_fire && write_q) begin
            if (addr_q >= MEM_BASE) begin
                mem_we = !busy_q;
            end else if (addr_q == '0) begin
                ctrl_start = apb.PWDATA[0] && !(busy_q && !done);
            end
        end

        if (done_eff) begin
            busy_d   = 1'b0;
            rv_d     = 1'b1;
            result_d = cat_result;
        end
        if (ctrl_start) begin
            busy_d = 1'b1;
            rv_d   = 1'b0;
        end
        start_d = ctrl_start;

        core_rd_data_d = (core_rd_addr >= MEM_BASE) ? mem[core_rd_addr] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            write_q        <= 1'b0;
            prdata_q       <= '0;
            core_rd_data_q <= '0;
            start_q        <= 1'b0;
            busy_q         <= 1'b0;
            rv_q           <= 1'b0;
            result_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            write_q        <= write_d;
            prdata_q       <= prdata_d;
            core_rd_data_q <= core_rd_data_d;
            start_q        <= start_d;
            busy_q         <= busy_d;
            rv_q           <= rv_d;
            result_q       <= result_d;
        end
    end

    // Memory has no reset; a reset during a transfer clears state_q, which gates mem_we.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= apb.PWDATA;
    end

    assign apb.PRDATA   = prdata_q;
    assign start        = start_q;
    assign busy         = busy_q;
    assign core_rd_data = core_rd_data_q;

endmodule

// File: tb/tb_apb_image_slave.sv
// Scoreboard bench for apb_image_slave: expected read data is queued when a
// transfer is issued and compared when PRDATA / core_rd_data become valid.
module tb_apb_image_slave;

    localparam int unsigned AW = 24;
    localparam int unsigned AD = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start;
    logic          busy;
    logic [AD-1:0] core_rd_addr = '0;
    logic [AW-1:0] core_rd_data;
    logic          done = 1'b0;
    logic          cat_result = 1'b0;

    int unsigned   tests_run    = 0;
    int unsigned   tests_failed = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] got;
    logic [AW-1:0] exp;

    apb_image_slave_if #(.Amba_Word(AW), .Amba_Addr_Depth(AD)) apb_if ();

    apb_image_slave #(
        .Amba_Word(AW),
        .Amba_Addr_Depth(AD),
        .Weight_precision(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .apb(apb_if),
        .start(start),
        .busy(busy),
        .core_rd_addr(core_rd_addr),
        .core_rd_data(core_rd_data),
        .done(done),
        .cat_result(cat_result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_idle();
        apb_if.PSEL    = 1'b0;
        apb_if.PENABLE = 1'b0;
        apb_if.PWRITE  = 1'b0;
        apb_if.PADDR   = '0;
        apb_if.PWDATA  = '0;
    endtask

    task automatic apb_write(input logic [AD-1:0] a, input logic [AW-1:0] d);
        @(posedge clk); #1;
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b1;
        apb_if.PADDR = a; apb_if.PWDATA = d;
        @(posedge clk); #1;
        apb_if.PENABLE = 1'b1;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic apb_read(input logic [AD-1:0] a, output logic [AW-1:0] data);
        @(posedge clk); #1;
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
        apb_if.PADDR = a;
        @(posedge clk); #1;
        apb_if.PENABLE = 1'b1;
        @(negedge clk);
        data = apb_if.PRDATA;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic core_read(input logic [AD-1:0] a, output logic [AW-1:0] data);
        @(posedge clk); #1;
        core_rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        data = core_rd_data;
    endtask

    task automatic pulse_done(input logic res);
        @(posedge clk); #1;
        done = 1'b1; cat_result = res;
        @(posedge clk); #1;
        done = 1'b0; cat_result = 1'b0;
    endtask

    task automatic test_reset();
        bus_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (apb_if.PRDATA !== '0 || start !== 1'b0 || busy !== 1'b0 || core_rd_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got PRDATA=%h start=%b busy=%b core=%h required all 0",
                     apb_if.PRDATA, start, busy, core_rd_data);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.push_back(24'h000000);
        apb_read(13'd1, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL reset_status: got %h required %h", got, exp);
        end
    endtask

    task automatic test_write_read();
        apb_write(13'd2, 24'hABCDEF);
        exp_q.push_back(24'hABCDEF);
        apb_read(13'd2, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL mem_read_addr2: got %h required %h", got, exp);
        end
        exp_q.push_back(24'h000000);
        apb_read(13'd0, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL ctrl_read_zero: got %h required %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b1;
        apb_if.PADDR = 13'd5; apb_if.PWDATA = 24'h000011;
        @(posedge clk); #1;
        apb_if.PENABLE = 1'b1;
        @(posedge clk); #1;
        apb_if.PENABLE = 1'b0;
        apb_if.PADDR = 13'd6; apb_if.PWDATA = 24'h000022;
        @(posedge clk); #1;
        apb_if.PENABLE = 1'b1;
        @(posedge clk); #1;
        bus_idle();
        exp_q.push_back(24'h000022);
        exp_q.push_back(24'h000011);
        exp_q.push_back(24'h000000);
        core_read(13'd6, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL b2b_core_addr6: got %h required %h", got, exp);
        end
        core_read(13'd5, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL b2b_core_addr5: got %h required %h", got, exp);
        end
        core_read(13'd1, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL core_low_addr_zero: got %h required %h", got, exp);
        end
    endtask

    task automatic test_start_busy();
        bit seen_start;
        apb_write(13'd3, 24'h111111);
        apb_write(13'd0, 24'hFFFFFE);
        seen_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (start === 1'b1 || busy === 1'b1) seen_start = 1'b1;
        end
        tests_run++;
        if (seen_start) begin
            tests_failed++;
            $display("FAIL ctrl_bit0_zero: got start/busy activity required none");
        end

        apb_write(13'd0, 24'h000001);
        @(negedge clk);
        tests_run++;
        if (start !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_pulse: got start=%b busy=%b required 1 1", start, busy);
        end
        @(negedge clk);
        tests_run++;
        if (start !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_one_cycle: got start=%b busy=%b required 0 1", start, busy);
        end

        exp_q.push_back(24'h000001);
        apb_read(13'd1, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL status_busy: got %h required %h", got, exp);
        end

        apb_write(13'd3, 24'h123456);
        exp_q.push_back(24'h111111);
        apb_read(13'd3, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL write_dropped_busy: got %h required %h", got, exp);
        end

        apb_write(13'd0, 24'h000001);
        seen_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (start === 1'b1) seen_start = 1'b1;
        end
        tests_run++;
        if (seen_start) begin
            tests_failed++;
            $display("FAIL restart_ignored: got start=1 required no pulse");
        end

        pulse_done(1'b1);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_clears_busy: got busy=%b required 0", busy);
        end
        exp_q.push_back(24'h000006);
        apb_read(13'd1, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL status_result: got %h required %h", got, exp);
        end

        pulse_done(1'b0);
        exp_q.push_back(24'h000006);
        apb_read(13'd1, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL done_idle_ignored: got %h required %h", got, exp);
        end
    endtask

    task automatic test_protocol_error();
        apb_write(13'd4, 24'h444444);
        exp_q.push_back(24'h444444);
        apb_read(13'd4, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL perr_pre_read: got %h required %h", got, exp);
        end
        @(posedge clk); #1;
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b1; apb_if.PWRITE = 1'b1;
        apb_if.PADDR = 13'd4; apb_if.PWDATA = 24'hBADBAD;
        repeat (2) @(posedge clk);
        #1;
        bus_idle();
        @(negedge clk);
        tests_run++;
        if (apb_if.PRDATA !== 24'h444444) begin
            tests_failed++;
            $display("FAIL perr_prdata_hold: got %h required %h", apb_if.PRDATA, 24'h444444);
        end
        exp_q.push_back(24'h444444);
        core_read(13'd4, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL perr_no_write: got %h required %h", got, exp);
        end
        exp_q.push_back(24'h000011);
        apb_read(13'd5, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL perr_then_read: got %h required %h", got, exp);
        end
    endtask

    task automatic test_done_start_collision();
        int unsigned pulses;
        apb_write(13'd0, 24'h000001);
        @(posedge clk); #1;
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b1;
        apb_if.PADDR = 13'd0; apb_if.PWDATA = 24'h000001;
        @(posedge clk); #1;
        apb_if.PENABLE = 1'b1;
        done = 1'b1; cat_result = 1'b0;
        @(posedge clk); #1;
        bus_idle();
        done = 1'b0;
        @(negedge clk);
        tests_run++;
        if (start !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision_start: got start=%b busy=%b required 1 1", start, busy);
        end
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (start === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL collision_single_pulse: got %0d extra pulses required 0", pulses);
        end
        exp_q.push_back(24'h000001);
        apb_read(13'd1, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL collision_status: got %h required %h", got, exp);
        end
        pulse_done(1'b0);
    endtask

    task automatic test_midreset();
        apb_write(13'd7, 24'h777777);
        exp_q.push_back(24'h777777);
        core_read(13'd7, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL pre_reset_core7: got %h required %h", got, exp);
        end
        exp_q.push_back(24'hABCDEF);
        apb_read(13'd2, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL pre_reset_read2: got %h required %h", got, exp);
        end
        @(posedge clk); #1;
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b1;
        apb_if.PADDR = 13'd7; apb_if.PWDATA = 24'h999999;
        @(posedge clk); #1;
        apb_if.PENABLE = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (apb_if.PRDATA !== '0 || start !== 1'b0 || busy !== 1'b0 || core_rd_data !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got PRDATA=%h start=%b busy=%b core=%h required all 0",
                     apb_if.PRDATA, start, busy, core_rd_data);
        end
        @(posedge clk); #1;
        bus_idle();
        rst = 1'b1;
        exp_q.push_back(24'h777777);
        core_read(13'd7, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL midreset_no_write: got %h required %h", got, exp);
        end
        exp_q.push_back(24'h000000);
        apb_read(13'd1, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL midreset_status: got %h required %h", got, exp);
        end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_start_busy();
        test_protocol_error();
        test_done_start_collision();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/apb_image_slave.md
Name: apb_image_slave

Overview:
- APB (AMBA 2, no PREADY/PSLVERR) responder that terminates the bus driven by the stimulus/initiator side of the cat recognizer environment.
- Decodes register and memory accesses, stores image pixels and weights into an internal word memory, and issues a single-cycle start pulse to the recognition core.
- Exposes a registered read port to the core and captures the core's result into a readable status register.

Parameters:
- Amba_Word, 24, APB data width and memory word width.
- Amba_Addr_Depth, 13, APB address width; memory spans addresses 2 .. 2^Amba_Addr_Depth-1.
- Weight_precision, 5, carried for interface compatibility; no width effect inside this block.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- PADDR  in  Amba_Addr_Depth  APB address.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable (ACCESS phase).
- PWRITE  in  1  1=write, 0=read.
- PWDATA  in  Amba_Word  APB write data.
- PRDATA  out  Amba_Word  APB read data.
- start  out  1  one-cycle start pulse to core.
- busy  out  1  high from start until done.
- core_rd_addr  in  Amba_Addr_Depth  core memory read address.
- core_rd_data  out  Amba_Word  core read data, 1-cycle latency.
- done  in  1  core completion strobe, 1 cycle.
- cat_result  in  1  core decision, valid when done=1.

Behaviour:
- Reset (rst=0, async): FSM=IDLE; PRDATA=0, start=0, busy=0, core_rd_data=0, status result bits=0. Memory contents are not reset.
- Address map:
  - 0 = CTRL (write bit0=1 requests start; reads return 0).
  - 1 = STATUS (bit0 busy, bit1 result_valid, bit2 result, upper bits 0; read-only, writes ignored).
  - >=2 = memory word.
- FSM states and transitions:
  - IDLE -> SETUP on PSEL=1, PENABLE=0.
  - SETUP -> ACCESS on PSEL=1, PENABLE=1. Address and direction are latched in SETUP.
  - ACCESS -> SETUP if PSEL=1, PENABLE=0 (back-to-back transfer); else -> IDLE.
  - PSEL=1, PENABLE=1 seen in IDLE (no SETUP) is a protocol error: no write, PRDATA unchanged, stay IDLE.
  - PSEL dropping in SETUP -> IDLE with no effect.
- Write: commits at the rising edge that ends the ACCESS cycle, using the address latched in SETUP. PWDATA is sampled in ACCESS.
- Read: PRDATA is registered at the end of SETUP and stable throughout ACCESS. It holds its value after the transfer until the next read.
- While busy=1:
  - Memory writes are dropped silently.
  - CTRL start writes are ignored.
  - Reads remain allowed.
- Start:
  - A CTRL write with bit0=1 while busy=0 -> start=1 for exactly the cycle after the ACCESS cycle, and busy=1 from that same cycle.
  - Writing 1 again while busy is ignored.
  - A CTRL write with bit0=0 has no effect.
- Done:
  - done=1 while busy=1 -> next cycle busy=0, result_valid=1, result=cat_result.
  - done while busy=0 is ignored.
  - A new start clears result_valid to 0 in the same cycle busy rises.
- Same-cycle done and start-request ACCESS: done is processed first (busy=0), then start is honoured, so busy stays 1, start pulses, and result_valid=0.
- Core port: core_rd_data = mem[core_rd_addr] registered, 1-cycle latency. For core_rd_addr<2, core_rd_data=0.
- Same-cycle APB write and core read of the same address: core reads the old data (read-before-write).
- Addresses wrap naturally within Amba_Addr_Depth bits; there are no out-of-range addresses.
- Mid-transfer reset: transfer aborted, no partial write, FSM=IDLE.

Test Plan:
- Reset then read STATUS -> PRDATA=0. Write 0xABCDEF to addr 2, then read addr 2 -> PRDATA=0xABCDEF during ACCESS.
- Back-to-back writes (ACCESS->SETUP) to addr 5 and 6 with 0x000011 and 0x000022; core_rd_addr=6 -> core_rd_data=0x000022 one cycle later.
- Write CTRL=1 -> start high exactly 1 cycle, busy=1. Write addr 3=0x123456 while busy, then read addr 3 -> old value. Pulse done with cat_result=1 -> STATUS reads 0x6.
- PSEL=1, PENABLE=1 without SETUP, PWRITE=1, addr 4 -> addr 4 unchanged, FSM remains IDLE.
- Drive done in the same cycle as a CTRL=1 ACCESS -> busy stays 1, one start pulse, result_valid=0.
- Assert rst=0 during the ACCESS of a write to addr 7 -> all outputs 0 immediately, addr 7 not written.
